// File: rtl/ser_pkg.sv
// Shared types for the parallel-to-serial front end of the sequence detector.
package ser_pkg;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'b00,
        SER_SHIFT = 2'b01
    } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// WIDTH-bit word -> 1 bit per enabled cycle; first bit 1 cycle after accept, no gap between words.
// Backpressure: in_ready drops only while the one-entry hold register is full; bit_en=0 freezes the shifter.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             bit_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] hold_data, hold_data_nxt;
    logic             hold_full, hold_full_nxt;
    logic             word_done_nxt;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sreg_shifted;

    assign in_ready  = !hold_full && !rst;
    assign accept    = in_valid && in_ready;
    assign last_bit  = (state == SER_SHIFT) && bit_en && (cnt == LAST);
    assign bit_valid = (state == SER_SHIFT) && bit_en;
    assign busy      = (state == SER_SHIFT) || hold_full;
    assign bit_out   = (state == SER_SHIFT) ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : 1'b0;

    assign sreg_shifted = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        hold_data_nxt = hold_data;
        hold_full_nxt = hold_full;
        word_done_nxt = 1'b0;
        case (state)
            SER_IDLE: begin
                if (accept) begin
                    sreg_nxt  = in_data;
                    cnt_nxt   = '0;
                    state_nxt = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (last_bit) begin
                    word_done_nxt = 1'b1;
                    cnt_nxt       = '0;
                    // Held word has priority; a same-cycle accept bypasses the hold register.
                    if (hold_full) begin
                        sreg_nxt      = hold_data;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        sreg_nxt = in_data;
                    end else begin
                        state_nxt = SER_IDLE;
                    end
                end else begin
                    if (bit_en) begin
                        sreg_nxt = sreg_shifted;
                        cnt_nxt  = cnt + CW'(1);
                    end
                    if (accept) begin
                        hold_data_nxt = in_data;
                        hold_full_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SER_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            cnt       <= cnt_nxt;
            hold_data <= hold_data_nxt;
            hold_full <= hold_full_nxt;
            word_done <= word_done_nxt;
        end
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end that feeds a single-bit sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per enabled cycle on bit_out; bit_out connects directly to the detector's in_bit input. A one-entry holding register lets back-to-back words stream with no idle bit slot. bit_en stalls the bit stream without losing data.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
LSB_FIRST, 0, 0 = emit MSB first, 1 = emit LSB first.

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  word to serialize
bit_en  input  1  bit-slot enable; 0 stalls shifting
bit_out  output  1  current serial bit (to detector in_bit)
bit_valid  output  1  bit_out is a live bit this cycle
busy  output  1  shift in progress or hold register occupied
word_done  output  1  registered 1-cycle pulse after the last bit of a word is emitted

Behaviour:
- State enum ser_state_t: SER_IDLE, SER_SHIFT. Registers: state, sreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], hold_data, hold_full, word_done.
- Reset (rst high at posedge): state=SER_IDLE, sreg=0, cnt=0, hold_full=0, word_done=0. rst wins over every other event, including mid-word; the partial word and the held word are discarded.
- in_ready = !hold_full && !rst (combinational). Accept = in_valid && in_ready.
- bit_valid = (state==SER_SHIFT) && bit_en. bit_out = sreg[WIDTH-1] (LSB_FIRST=0) or sreg[0] (LSB_FIRST=1) when state==SER_SHIFT; otherwise 0.
- busy = (state==SER_SHIFT) || hold_full.
- SER_IDLE: on accept, in_data loads into sreg, cnt=0, go to SER_SHIFT. The first bit is valid in the cycle after the accept edge (latency 1). The hold register stays empty.
- SER_SHIFT, accept while not on the last bit: in_data goes into hold_data, hold_full=1.
- SER_SHIFT, bit_en=0: sreg, cnt and state hold. Accept into hold is still permitted.
- SER_SHIFT, bit_en=1, cnt<WIDTH-1: shift sreg toward the output end (zero fill), cnt+1.
- Last bit (bit_en=1, cnt==WIDTH-1): word_done=1 next cycle. Next word is chosen in this order:
  - hold_full=1: sreg gets hold_data, hold_full=0, cnt=0, stay in SER_SHIFT.
  - Otherwise, accept in the same cycle: in_data bypasses directly into sreg, cnt=0, stay in SER_SHIFT.
  - Otherwise: go to SER_IDLE.
  - In all cases there is no gap bit between words.
- word_done is 0 in every other cycle.
- in_data is ignored when accept=0. in_valid may drop without an accept; no protocol error is flagged.

Decomposition:
- Package ser_pkg: ser_state_t enum (2-bit logic, SER_IDLE=2'b00, SER_SHIFT=2'b01).
- No sub-module: the holding register and counter stay inline.
- Integration top (test-only wrapper) instantiates bit_serializer -> detector FSM, with bit_out driving in_bit; this tests composition only.

Test Plan:
- Reset then single word: WIDTH=8, LSB_FIRST=0, accept 8'hA5, bit_en=1 -> bit_out 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; word_done pulse 1 cycle after the 8th bit; then state idle, busy=0.
- Back-to-back: accept 8'hF0 then 8'h0F while the first is shifting -> 16 contiguous bit_valid cycles 1111000000001111; in_ready=0 while hold_full; exactly two word_done pulses.
- Stall: during 8'hC3, hold bit_en=0 for 3 cycles after bit 2 -> bit_valid=0 for those cycles, stream resumes with bit 3; full sequence 11000011 is unchanged.
- LSB_FIRST=1, accept 8'h01 -> bit_out 1,0,0,0,0,0,0,0.
- Same-cycle bypass: hold empty, in_valid asserted exactly on the last-bit cycle with 8'h80 -> next bit is 1 with no gap; hold_full stays 0.
- Mid-word reset: assert rst after bit 4 of 8'hFF with a word held -> next cycle bit_valid=0, busy=0, in_ready=1 after rst drops, no word_done pulse.
